// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit_pkg
//  Brief    : Shared definitions for the multi-cycle multiply/divide unit:
//             architectural width, operation codes, FSM states, op helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package muldiv_unit_pkg;

  // Default architectural register width
  localparam int ARCH_WIDTH = 32;

  // Operation code encoding
  localparam int MDOp_WIDTH = 3;
  localparam logic [MDOp_WIDTH-1:0] MDOp_MULLW  = 3'b000;
  localparam logic [MDOp_WIDTH-1:0] MDOp_MULHW  = 3'b001;
  localparam logic [MDOp_WIDTH-1:0] MDOp_MULHWU = 3'b010;
  localparam logic [MDOp_WIDTH-1:0] MDOp_DIVW   = 3'b100;
  localparam logic [MDOp_WIDTH-1:0] MDOp_DIVWU  = 3'b101;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Operations that work on absolute values and correct the sign in FIX
  function automatic logic is_signed_op(input logic [MDOp_WIDTH-1:0] op);
    return (op == MDOp_MULLW) || (op == MDOp_MULHW) || (op == MDOp_DIVW);
  endfunction

  function automatic logic is_div_op(input logic [MDOp_WIDTH-1:0] op);
    return (op == MDOp_DIVW) || (op == MDOp_DIVWU);
  endfunction

  function automatic logic is_legal_op(input logic [MDOp_WIDTH-1:0] op);
    return (op == MDOp_MULLW) || (op == MDOp_MULHW) || (op == MDOp_MULHWU) ||
           (op == MDOp_DIVW)  || (op == MDOp_DIVWU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_step.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_step
//  Brief    : One combinational radix-2 iteration. Multiply: conditional add
//             of the multiplicand into the upper half, then shift right.
//             Divide: shift left, trial subtract, restore on borrow and
//             shift the quotient bit into the low half.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 mode_i,   // 0 = multiply, 1 = divide
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opnd_i,   // multiplicand or divisor magnitude
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0] w_mul_sum;
  logic [WIDTH:0] w_div_rem;
  logic [WIDTH:0] w_div_trial;
  logic           w_qbit;

  // Compute both iteration kinds and select by mode
  always_comb begin
    w_mul_sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} +
                  (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    // Partial remainder shifted left with the next dividend bit
    w_div_rem   = acc_i[2*WIDTH-1:WIDTH-1];
    w_div_trial = w_div_rem - {1'b0, opnd_i};
    // Remainder stays below the divisor, so bit WIDTH is a pure borrow flag
    w_qbit      = ~w_div_trial[WIDTH];
    if (mode_i) begin
      acc_o = {(w_qbit ? w_div_trial[WIDTH-1:0] : w_div_rem[WIDTH-1:0]),
               acc_i[WIDTH-2:0], w_qbit};
    end else begin
      acc_o = {w_mul_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Brief    : Iterative integer multiply/divide for the execute stage with
//             start/ready/done handshake, flush, overflow and CR0 flags.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = ARCH_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [MDOp_WIDTH-1:0] op_i,
  input  logic [0:WIDTH-1]      a_i,
  input  logic [0:WIDTH-1]      b_i,
  input  logic                  flush_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [0:WIDTH-1]      result_o,
  output logic                  ov_o,
  output logic [2:0]            cr0_o
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  md_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q;
  logic [2*WIDTH-1:0]        acc_q;
  logic [WIDTH-1:0]          opnd_q;
  logic [MDOp_WIDTH-1:0]     op_q;
  logic                      neg_q;
  logic [WIDTH-1:0]          result_q;
  logic                      ov_q;
  logic [2:0]                cr0_q;

  logic [WIDTH-1:0]   w_a, w_b, w_a_mag, w_b_mag;
  logic               w_signed, w_a_neg, w_b_neg;
  logic               w_accept, w_early, w_illegal;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quot_s;
  logic [WIDTH-1:0]   w_fix_res;
  logic               w_fix_ov;

  // Operand decode at accept: magnitudes and early-out detection
  always_comb begin
    w_a       = a_i;
    w_b       = b_i;
    w_signed  = is_signed_op(op_i);
    w_a_neg   = w_signed & w_a[WIDTH-1];
    w_b_neg   = w_signed & w_b[WIDTH-1];
    w_a_mag   = w_a_neg ? -w_a : w_a;
    w_b_mag   = w_b_neg ? -w_b : w_b;
    w_illegal = ~is_legal_op(op_i);
    w_early   = w_illegal ||
                (is_div_op(op_i) && (w_b == '0)) ||
                ((op_i == MDOp_DIVW) && (w_a == {1'b1, {(WIDTH-1){1'b0}}}) &&
                 (w_b == '1));
    w_accept  = start_i & ready_o & ~flush_i;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_i (is_div_op(op_q)),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (w_step)
  );

  // Sign correction and overflow for the final result
  always_comb begin
    w_prod_s  = neg_q ? -acc_q : acc_q;
    w_quot_s  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    w_fix_res = '1;
    w_fix_ov  = 1'b0;
    case (op_q)
      MDOp_MULLW: begin
        w_fix_res = w_prod_s[WIDTH-1:0];
        w_fix_ov  = ~((&w_prod_s[2*WIDTH-1:WIDTH-1]) | ~(|w_prod_s[2*WIDTH-1:WIDTH-1]));
      end
      MDOp_MULHW:  w_fix_res = w_prod_s[2*WIDTH-1:WIDTH];
      MDOp_MULHWU: w_fix_res = acc_q[2*WIDTH-1:WIDTH];
      MDOp_DIVW:   w_fix_res = w_quot_s;
      MDOp_DIVWU:  w_fix_res = acc_q[WIDTH-1:0];
      default:     w_fix_res = '1;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (w_accept) state_d = w_early ? ST_DONE : ST_RUN;
        else          state_d = ST_IDLE;
      end
      ST_RUN:  if (cnt_q == '0) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  // Handshake outputs decoded from the registered state
  always_comb begin
    ready_o = (state_q == ST_IDLE) || (state_q == ST_DONE);
    done_o  = (state_q == ST_DONE);
  end

  // Datapath: operand load, iteration, and result/flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      ov_q     <= 1'b0;
      cr0_q    <= 3'b000;
    end else if (w_accept) begin
      op_q  <= op_i;
      cnt_q <= CNT_LOAD;
      if (is_div_op(op_i)) begin
        acc_q  <= {{WIDTH{1'b0}}, w_a_mag};
        opnd_q <= w_b_mag;
      end else begin
        acc_q  <= {{WIDTH{1'b0}}, w_b_mag};
        opnd_q <= w_a_mag;
      end
      neg_q <= w_a_neg ^ w_b_neg;
      if (w_early) begin
        result_q <= w_illegal ? '1 : '0;
        ov_q     <= ~w_illegal;
        cr0_q    <= w_illegal ? 3'b100 : 3'b001;
      end
    end else if (!flush_i && state_q == ST_RUN) begin
      acc_q <= w_step;
      cnt_q <= cnt_q - 1'b1;
    end else if (!flush_i && state_q == ST_FIX) begin
      result_q <= w_fix_res;
      ov_q     <= w_fix_ov;
      cr0_q    <= {w_fix_res[WIDTH-1],
                   ~w_fix_res[WIDTH-1] & (|w_fix_res),
                   ~(|w_fix_res)};
    end
  end

  assign result_o = result_q;
  assign ov_o     = ov_q;
  assign cr0_o    = cr0_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Brief    : Directed self-checking bench for muldiv_unit (WIDTH=32).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam logic [2:0] OP_MULLW  = 3'b000;
  localparam logic [2:0] OP_MULHW  = 3'b001;
  localparam logic [2:0] OP_MULHWU = 3'b010;
  localparam logic [2:0] OP_ILL    = 3'b011;
  localparam logic [2:0] OP_DIVW   = 3'b100;
  localparam logic [2:0] OP_DIVWU  = 3'b101;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [0:31] a, b, result;
  logic        ready, done, ov;
  logic [2:0]  cr0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .flush_i  (flush),
    .ready_o  (ready),
    .done_o   (done),
    .result_o (result),
    .ov_o     (ov),
    .cr0_o    (cr0)
  );

  // Issue one operation and return the cycle offset of done (0 = timeout)
  task automatic do_op(input logic [2:0] o, input logic [0:31] x, input logic [0:31] y,
                       output int lat);
    @(negedge clk); op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    #3;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_ov got %b want 0", ov); end
    checks++; if (cr0 !== 3'b000) begin errors++; $display("FAIL reset_cr0 got %b want 000", cr0); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_mul();
    int lat;
    do_op(OP_MULLW, 32'h0001_0000, 32'h0001_0000, lat);
    checks++; if (lat !== 34) begin errors++; $display("FAIL mullw_latency got %0d want 34", lat); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL mullw_result got %h want 00000000", result); end
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL mullw_ov got %b want 1", ov); end
    checks++; if (cr0 !== 3'b001) begin errors++; $display("FAIL mullw_cr0 got %b want 001", cr0); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL done_ready got %b want 1", ready); end
    do_op(OP_MULLW, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++; if (result !== 32'h1) begin errors++; $display("FAIL mullw_m1_result got %h want 00000001", result); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL mullw_m1_ov got %b want 0", ov); end
    checks++; if (cr0 !== 3'b010) begin errors++; $display("FAIL mullw_m1_cr0 got %b want 010", cr0); end
    do_op(OP_MULHW, 32'hFFFF_FFFE, 32'h0000_0003, lat);
    checks++; if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhw_result got %h want ffffffff", result); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL mulhw_ov got %b want 0", ov); end
    checks++; if (cr0 !== 3'b100) begin errors++; $display("FAIL mulhw_cr0 got %b want 100", cr0); end
    do_op(OP_MULHWU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++; if (result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhwu_result got %h want fffffffe", result); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL mulhwu_ov got %b want 0", ov); end
  endtask

  task automatic test_div();
    int lat;
    do_op(OP_DIVW, 32'hFFFF_FFF9, 32'h0000_0002, lat);
    checks++; if (lat !== 34) begin errors++; $display("FAIL divw_latency got %0d want 34", lat); end
    checks++; if (result !== 32'hFFFF_FFFD) begin errors++; $display("FAIL divw_result got %h want fffffffd", result); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL divw_ov got %b want 0", ov); end
    checks++; if (cr0 !== 3'b100) begin errors++; $display("FAIL divw_cr0 got %b want 100", cr0); end
    do_op(OP_DIVWU, 32'hFFFF_FFF9, 32'h0000_0002, lat);
    checks++; if (result !== 32'h7FFF_FFFC) begin errors++; $display("FAIL divwu_result got %h want 7ffffffc", result); end
    checks++; if (cr0 !== 3'b010) begin errors++; $display("FAIL divwu_cr0 got %b want 010", cr0); end
    do_op(OP_DIVW, 32'd100, 32'hFFFF_FFF9, lat);
    checks++; if (result !== 32'hFFFF_FFF2) begin errors++; $display("FAIL divw_100_m7 got %h want fffffff2", result); end
  endtask

  task automatic test_early_out();
    int lat;
    do_op(OP_DIVW, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL divw_ovf_latency got %0d want 1", lat); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL divw_ovf_result got %h want 0", result); end
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL divw_ovf_ov got %b want 1", ov); end
    checks++; if (cr0 !== 3'b001) begin errors++; $display("FAIL divw_ovf_cr0 got %b want 001", cr0); end
    do_op(OP_DIVWU, 32'h1234_5678, 32'h0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL divwu_z_latency got %0d want 1", lat); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL divwu_z_result got %h want 0", result); end
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL divwu_z_ov got %b want 1", ov); end
    do_op(OP_ILL, 32'h5, 32'h6, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL illegal_latency got %0d want 1", lat); end
    checks++; if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL illegal_result got %h want ffffffff", result); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL illegal_ov got %b want 0", ov); end
    checks++; if (cr0 !== 3'b100) begin errors++; $display("FAIL illegal_cr0 got %b want 100", cr0); end
  endtask

  task automatic test_flush();
    int seen;
    @(negedge clk); op = OP_MULLW; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL run_ready got %b want 0", ready); end
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done got %b want 0", done); end
    checks++; if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL flush_result got %h want ffffffff", result); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (done) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_done got %0d want 0", seen); end
    @(negedge clk); op = OP_MULLW; a = 32'd3; b = 32'd5; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL start_flush_ready got %b want 1", ready); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (done) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL start_flush_done got %0d want 0", seen); end
  endtask

  task automatic test_reset_mid();
    int lat;
    do_op(OP_MULLW, 32'h0001_0001, 32'h0001_0000, lat);
    checks++; if (result !== 32'h0001_0000) begin errors++; $display("FAIL mullw_pre_result got %h want 00010000", result); end
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL mullw_pre_ov got %b want 1", ov); end
    @(negedge clk); op = OP_MULLW; a = 32'd7; b = 32'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL rstmid_result got %h want 0", result); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL rstmid_ov got %b want 0", ov); end
    checks++; if (cr0 !== 3'b000) begin errors++; $display("FAIL rstmid_cr0 got %b want 000", cr0); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat;
    int extra;
    do_op(OP_MULHWU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++; if (ready !== 1'b1 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_done_ready got ready=%b done=%b want 1 1", ready, done);
    end
    op = OP_MULLW; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 5) begin
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_run_ready got %b want 0", ready); end
        op = OP_ILL; start = 1'b1;
      end
      if (n == 6) start = 1'b0;
      if (done) begin lat = n; break; end
    end
    checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency got %0d want 34", lat); end
    checks++; if (result !== 32'd42) begin errors++; $display("FAIL b2b_result got %h want 0000002a", result); end
    checks++; if (cr0 !== 3'b010) begin errors++; $display("FAIL b2b_cr0 got %b want 010", cr0); end
    extra = 0;
    repeat (40) begin @(negedge clk); if (done) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_extra_done got %0d want 0", extra); end
    checks++; if (result !== 32'd42) begin errors++; $display("FAIL b2b_hold got %h want 0000002a", result); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_early_out();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
